// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader that streams a checksummed image into instruction memory
module imem_loader #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SYNC     = 8'hA5;

  // ---------------------------------------------------------------------------
  // rx synchronizer; rx_prev gives a synchronous falling-edge detector
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // two-flop synchronizer plus one delayed copy, all idle-high on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // UART 8N1 receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t   rx_state;
  rx_state_t   rx_next;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_valid;
  logic        frame_err;
  logic        tick_half;
  logic        tick_full;

  assign tick_half = (bit_cnt == HALF_BIT);
  assign tick_full = (bit_cnt == FULL_BIT);

  // receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // receiver next state: a start that is high again at mid-bit is a glitch
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (tick_half) rx_next = rx_sync ? RX_IDLE : RX_BITS;
      RX_BITS:  if (tick_full && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // bit timing, LSB-first shift register and per-byte result strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || (rx_state == RX_START && tick_half) || tick_full)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 16'd1;
      case (rx_state)
        RX_START: bit_idx <= '0;
        RX_BITS: if (tick_full) begin
          shreg   <= {rx_sync, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        RX_STOP: if (tick_full) begin
          if (rx_sync) byte_valid <= 1'b1;
          else         frame_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, FINISH} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;

  // frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // frame next state; DATA stays put through the write cycle so imem_we is
  // always seen inside DATA, and leaves for CSUM once the last word is out
  always_comb begin
    state_next = state;
    if (frame_err) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:   if (byte_valid && shreg == SYNC) state_next = LEN_LO;
        LEN_LO: if (byte_valid) state_next = LEN_HI;
        LEN_HI: if (byte_valid) state_next = ({shreg, len[7:0]} != 16'd0) ? DATA : CSUM;
        DATA:   if (imem_we && word_cnt == len) state_next = CSUM;
        CSUM:   if (byte_valid) state_next = (shreg == csum) ? FINISH : IDLE;
        FINISH: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign cpu_hold = (state != IDLE);
  assign done     = (state == FINISH);

  // frame datapath: length, word assembly, write strobe, checksum, sticky err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      if (frame_err) err <= 1'b1;
      case (state)
        IDLE: if (byte_valid && shreg == SYNC) begin
          err       <= 1'b0;
          len       <= '0;
          word_cnt  <= '0;
          byte_idx  <= '0;
          csum      <= '0;
          imem_addr <= '0;
        end
        LEN_LO: if (byte_valid) len[7:0]  <= shreg;
        LEN_HI: if (byte_valid) len[15:8] <= shreg;
        DATA: begin
          if (imem_we) begin
            imem_we   <= 1'b0;
            imem_addr <= imem_addr + 1'b1;
          end else if (byte_valid) begin
            csum     <= csum ^ shreg;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: imem_wdata[7:0]   <= shreg;
              2'd1: imem_wdata[15:8]  <= shreg;
              2'd2: imem_wdata[23:16] <= shreg;
              default: imem_wdata[31:24] <= shreg;
            endcase
            if (byte_idx == 2'd3) begin
              imem_we  <= 1'b1;
              word_cnt <= word_cnt + 16'd1;
            end
          end
        end
        CSUM: if (byte_valid && shreg != csum) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_count  = 0;
  int          done_count = 0;
  int          hold_viol = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // log writes and done pulses away from the active edge
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_count < 16) begin
        wr_addr[wr_count] = 32'(imem_addr);
        wr_data[wr_count] = imem_wdata;
      end
      if (!cpu_hold) hold_viol = hold_viol + 1;
      wr_count = wr_count + 1;
    end
    if (done) done_count = done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_count   = 0;
    done_count = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_we",    32'(imem_we),   32'd0);
    check("reset_addr",  32'(imem_addr), 32'd0);
    check("reset_wdata", imem_wdata,     32'd0);
    check("reset_hold",  32'(cpu_hold),  32'd0);
    check("reset_done",  32'(done),      32'd0);
    check("reset_err",   32'(err),       32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // basic load: two words, XOR of data bytes 13^93^10 = 90
    clear_log();
    send_byte(8'hA5, 1'b1);
    check("basic_hold_after_sync", 32'(cpu_hold), 32'd1);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    check("basic_hold_in_data", 32'(cpu_hold), 32'd1);
    send_byte(8'h00, 1'b1);
    check("basic_hold_before_csum", 32'(cpu_hold), 32'd1);
    send_byte(8'h90, 1'b1);
    repeat (10) @(negedge clk);
    check("basic_writes", 32'(wr_count), 32'd2);
    check("basic_addr0",  wr_addr[0], 32'd0);
    check("basic_data0",  wr_data[0], 32'h0000_0013);
    check("basic_addr1",  wr_addr[1], 32'd1);
    check("basic_data1",  wr_data[1], 32'h0010_0093);
    check("basic_done",   32'(done_count), 32'd1);
    check("basic_err",    32'(err), 32'd0);
    check("basic_hold_end", 32'(cpu_hold), 32'd0);

    // bad checksum
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    check("badcs_writes", 32'(wr_count), 32'd2);
    check("badcs_err",    32'(err), 32'd1);
    check("badcs_done",   32'(done_count), 32'd0);
    check("badcs_hold",   32'(cpu_hold), 32'd0);

    // N=0 with a start glitch injected after the sync byte
    clear_log();
    send_byte(8'hA5, 1'b1);
    check("n0_err_cleared", 32'(err), 32'd0);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    check("n0_writes", 32'(wr_count), 32'd0);
    check("n0_done",   32'(done_count), 32'd1);
    check("n0_err",    32'(err), 32'd0);

    // framing error during LEN_HI
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_err",    32'(err), 32'd1);
    check("ferr_hold",   32'(cpu_hold), 32'd0);
    check("ferr_writes", 32'(wr_count), 32'd0);
    // FSM must be back in IDLE: further payload bytes are ignored
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    check("ferr_idle_writes", 32'(wr_count), 32'd0);
    check("ferr_idle_hold",   32'(cpu_hold), 32'd0);

    // reset abort after word 1 of a 3-word load
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    check("abort_first_write", 32'(wr_count), 32'd1);
    check("abort_first_data",  wr_data[0], 32'hDEAD_BEEF);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_rst_we",    32'(imem_we),   32'd0);
    check("abort_rst_addr",  32'(imem_addr), 32'd0);
    check("abort_rst_wdata", imem_wdata,     32'd0);
    check("abort_rst_hold",  32'(cpu_hold),  32'd0);
    check("abort_rst_done",  32'(done),      32'd0);
    check("abort_rst_err",   32'(err),       32'd0);
    rst = 1'b0;
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    check("abort_no_more_writes", 32'(wr_count), 32'd1);

    // fresh 1-word load after abort: 78^56^34^12 = 08
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (10) @(negedge clk);
    check("reload_writes", 32'(wr_count), 32'd1);
    check("reload_addr",   wr_addr[0], 32'd0);
    check("reload_data",   wr_data[0], 32'h1234_5678);
    check("reload_done",   32'(done_count), 32'd1);

    // wrap: 5 words into a 4-word memory, checksum 1^2^3^4^5 = 01
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1);
    for (int w = 1; w <= 5; w++) begin
      send_byte(8'(w), 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    end
    send_byte(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    check("wrap_writes", 32'(wr_count), 32'd5);
    check("wrap_addr3",  wr_addr[3], 32'd3);
    check("wrap_addr4",  wr_addr[4], 32'd0);
    check("wrap_data4",  wr_data[4], 32'd5);
    check("wrap_done",   32'(done_count), 32'd1);
    check("wrap_err",    32'(err), 32'd0);

    check("hold_during_writes", 32'(hold_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
